// File: rtl/add_rr_arbiter.sv
// add_rr_arbiter: round-robin shared N-bit adder with one registered response slot
module add_rr_arbiter #(
    parameter int N    = 64,
    parameter int REQ  = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REQ-1:0]   req_valid,
    output logic [REQ-1:0]   req_ready,
    input  logic [REQ*N-1:0] req_a,
    input  logic [REQ*N-1:0] req_b,
    input  logic [REQ-1:0]   req_cin,
    input  logic [REQ-1:0]   req_signed,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [N-1:0]     rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_neg,
    output logic             rsp_ovf,
    output logic             rsp_zero,
    output logic [CNTW-1:0]  txn_count
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d, id_q, id_d, gidx;
    logic [N-1:0]    sum_q, sum_d, a, b;
    logic            cout_q, cout_d, neg_q, neg_d, ovf_q, ovf_d, zero_q, zero_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [N:0]      full_sum;
    logic            found, slot_free, accept, complete, sgn;
    assign slot_free = rst_n && (state_q == EMPTY || rsp_ready);
    always_comb begin
        logic [IDW:0] j;
        found = 1'b0;
        gidx  = '0;
        j     = '0;
        for (int k = 0; k < REQ; k++) begin
            j = {1'b0, ptr_q} + (IDW+1)'(k);
            j = j >= (IDW+1)'(REQ) ? j - (IDW+1)'(REQ) : j;
            if (!found && req_valid[j[IDW-1:0]]) begin
                found = 1'b1;
                gidx  = j[IDW-1:0];
            end
        end
    end
    assign accept    = found && slot_free;
    assign complete  = state_q == FULL && rsp_ready;
    assign req_ready = accept ? REQ'(1) << gidx : '0;
    assign a         = req_a[gidx*N +: N];
    assign b         = req_b[gidx*N +: N];
    assign sgn       = req_signed[gidx];
    assign full_sum  = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, req_cin[gidx]};
    always_comb begin
        state_d = accept ? FULL : complete ? EMPTY : state_q;
        ptr_d   = accept ? (gidx == IDW'(REQ-1) ? '0 : gidx + 1'b1) : ptr_q;
        id_d    = accept ? gidx : id_q;
        sum_d   = accept ? full_sum[N-1:0] : sum_q;
        cout_d  = accept ? full_sum[N] : cout_q;
        neg_d   = accept ? sgn && full_sum[N-1] : neg_q;
        ovf_d   = accept ? (sgn ? (a[N-1] == b[N-1]) && (full_sum[N-1] != a[N-1]) : full_sum[N]) : ovf_q;
        zero_d  = accept ? full_sum[N-1:0] == '0 : zero_q;
        cnt_d   = cnt_q + CNTW'(complete);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            id_q    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_d;
        end
    end
    assign rsp_valid = state_q == FULL;
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_neg   = neg_q;
    assign rsp_ovf   = ovf_q;
    assign rsp_zero  = zero_q;
    assign txn_count = cnt_q;
endmodule

// File: doc/add_rr_arbiter.md
Name: add_rr_arbiter

Overview:
- Shares one N-bit adder datapath (a+b+cin, with negative, overflow, zero and carry flags) between REQ requesters.
- Each requester has a valid/ready request port; all requesters share one registered response port with valid/ready and a requester ID.
- Arbitration is round-robin. Results are registered, giving 1-cycle latency and full throughput under no backpressure.
- Sits between the ALU-issue clients and the adder, replacing per-client adder instances.

Parameters:
- N, 64, operand and sum width.
- REQ, 4, number of requesters (2..8).
- IDW, 2, width of rsp_id; must satisfy 2**IDW >= REQ.
- CNTW, 16, width of the completed-transaction counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  REQ  per-requester request valid.
- req_ready  output  REQ  per-requester accept (one-hot or zero).
- req_a  input  REQ*N  operand a, requester i in bits [i*N +: N].
- req_b  input  REQ*N  operand b, same packing as req_a.
- req_cin  input  REQ  carry-in per requester.
- req_signed  input  REQ  signed interpretation per requester.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  IDW  index of the requester that owns the response.
- rsp_sum  output  N  raw two's-complement sum, (a+b+cin) mod 2**N.
- rsp_cout  output  1  carry out of bit N-1.
- rsp_neg  output  1  rsp_sum[N-1] when signed, else 0.
- rsp_ovf  output  1  signed: (a[N-1]==b[N-1]) && (sum[N-1]!=a[N-1]); unsigned: cout.
- rsp_zero  output  1  rsp_sum==0.
- txn_count  output  CNTW  number of completed responses, wrapping.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_neg=0, rsp_ovf=0, rsp_zero=0.
  - txn_count=0, rr pointer=0.
  - req_ready is combinational, so it is 0 during reset.
- State machine:
  - EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - slot_free = EMPTY || (FULL && rsp_ready).
- Arbitration (combinational):
  - When slot_free, grant the first i with req_valid[i]=1, searching from ptr upward with wrap modulo REQ.
  - req_ready = grant, which is one-hot.
  - When not slot_free, req_ready=0.
  - req_ready never asserts for a requester whose req_valid=0.
- Accept:
  - An accept occurs when a grant exists; at the clock edge the adder result of the granted operands is registered into the rsp_* outputs.
  - rsp_id <= granted index; FSM goes to FULL; ptr <= (grant index + 1) mod REQ.
- Complete:
  - A completion occurs when FULL && rsp_ready; txn_count increments by 1 and wraps at 2**CNTW.
  - A completion with no accept in the same cycle moves the FSM to EMPTY.
  - A completion and an accept in the same cycle keep the FSM FULL with the new result; back-to-back throughput is 1 per cycle.
- Latency: exactly 1 cycle from accept edge to rsp_valid=1 with the result.
- Backpressure: while FULL && !rsp_ready, every rsp_* output holds stable and no request is granted.
- Pointer: ptr changes only on accept, never while idle.
- Fairness: a requester holding req_valid continuously is granted within REQ accepts.
- Requester rule: requesters hold operands stable while req_valid=1 and not yet accepted. The arbiter samples operands only on the accept edge.
- Arithmetic:
  - Full N+1-bit sum of a, b and cin.
  - Flags are computed from the operands and sum of the same transaction.
  - The sum is always raw two's complement; no magnitude conversion.
- Reset asserted mid-transaction: the pending response is discarded, all outputs return to reset values immediately, and ptr returns to 0.

Test Plan:
- Single request: N=64; req0 a=5, b=7, cin=0, signed=0, rsp_ready=1.
  - -> req_ready[0]=1 in the accept cycle.
  - -> Next cycle: rsp_valid=1, id=0, sum=12, cout=0, ovf=0, neg=0, zero=0; txn_count=1 after completion.
- Signed overflow: req1 a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0, signed=1.
  - -> sum=0x8000_0000_0000_0000, neg=1, ovf=1, cout=0, id=1.
- Zero and carry: req2 a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1, signed=0.
  - -> sum=0, cout=1, zero=1, ovf=1, neg=0.
- Round-robin: all four req_valid held high with rsp_ready=1.
  - -> grants 0,1,2,3,0,1 on consecutive cycles.
  - -> rsp_id follows the same sequence 1 cycle later; txn_count=6 after 6 completions.
- Backpressure: accept req3, then hold rsp_ready=0 for 5 cycles with req0 valid.
  - -> rsp_* stable and req_ready=0 for all 5 cycles.
  - -> Raising rsp_ready completes req3 and accepts req0 in the same cycle; rsp_valid stays 1.
- Reset mid-operation: assert rst_n=0 while FULL.
  - -> rsp_valid=0, txn_count=0, all rsp_* outputs 0 asynchronously.
  - -> After release, req1 and req2 both valid: req1 is granted first (ptr=0).
